// File: rtl/simple_uart_pkg.sv
// rtl/simple_uart_pkg.sv - shared state encoding, frame constants and parity helper for the UART transmitter
package simple_uart_pkg;

   localparam int DATA_BITS     = 8;
   localparam int PARITY_BITS   = 1;
   localparam int STOP_BITS_ONE = 1;
   localparam int STOP_BITS_TWO = 2;
   localparam int BIT_CNT_W     = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - loadable bit-period down-counter; o_tick marks the last cycle of a bit
module uart_baud_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic [DIV_WIDTH-1:0] i_load_val,
   output logic                 o_tick
);

   logic [DIV_WIDTH-1:0] r_count;

   // Holds at zero instead of wrapping so an idle counter keeps reporting bit end.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - DIV_WIDTH'(1);
      end
   end

   assign o_tick = (r_count == '0);

endmodule

// File: rtl/simple_uart_tx.sv
// rtl/simple_uart_tx.sv - FIFO-fed 8-bit UART transmitter with optional parity and one or two stop bits
module simple_uart_tx
   import simple_uart_pkg::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [DIV_WIDTH-1:0] i_clkdiv,
   input  logic                 i_parity_en,
   input  logic                 i_parity_odd,
   input  logic                 i_two_stop,
   input  logic                 i_enable,
   input  logic [7:0]           i_fifo_data,
   input  logic                 i_fifo_empty,
   output logic                 o_fifo_read,
   output logic                 o_tx,
   output logic                 o_busy
);

   state_t                 r_state;
   state_t                 w_next_state;
   logic [DATA_BITS-1:0]   r_data;
   logic [DIV_WIDTH-1:0]   r_clkdiv;
   logic                   r_parity_en;
   logic                   r_parity_odd;
   logic                   r_two_stop;
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic                   r_tx;

   logic                   w_start_frame;
   logic                   w_tick;
   logic                   w_load;
   logic [DIV_WIDTH-1:0]   w_load_val;
   logic                   w_next_tx;
   logic                   w_bit_clr;
   logic                   w_bit_inc;
   logic                   w_last_data;
   logic                   w_last_stop;

   assign w_start_frame = (r_state == ST_IDLE) && i_enable && !i_fifo_empty && !i_rst;
   // The first bit period is loaded from the live divisor, as it is captured on that same edge.
   assign w_load_val    = w_start_frame ? (i_clkdiv - DIV_WIDTH'(1)) : (r_clkdiv - DIV_WIDTH'(1));
   assign w_last_data   = (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1));
   assign w_last_stop   = (r_bit_cnt == (r_two_stop ? BIT_CNT_W'(STOP_BITS_TWO - 1)
                                                    : BIT_CNT_W'(STOP_BITS_ONE - 1)));

   uart_baud_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_tick     (w_tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_tx         <= 1'b1;
         r_bit_cnt    <= '0;
         r_data       <= '0;
         r_clkdiv     <= '0;
         r_parity_en  <= 1'b0;
         r_parity_odd <= 1'b0;
         r_two_stop   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_tx    <= w_next_tx;
         if (w_start_frame) begin
            r_data       <= i_fifo_data;
            r_clkdiv     <= i_clkdiv;
            r_parity_en  <= i_parity_en;
            r_parity_odd <= i_parity_odd;
            r_two_stop   <= i_two_stop;
         end
         if (w_bit_clr) begin
            r_bit_cnt <= '0;
         end else if (w_bit_inc) begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_tx    = r_tx;
      w_load       = 1'b0;
      w_bit_clr    = 1'b0;
      w_bit_inc    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_next_tx = 1'b1;
            if (w_start_frame) begin
               w_next_state = ST_START;
               w_next_tx    = 1'b0;
               w_load       = 1'b1;
               w_bit_clr    = 1'b1;
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_next_state = ST_DATA;
               w_next_tx    = r_data[0];
               w_load       = 1'b1;
               w_bit_clr    = 1'b1;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               w_load = 1'b1;
               if (w_last_data) begin
                  w_bit_clr = 1'b1;
                  if (r_parity_en) begin
                     w_next_state = ST_PARITY;
                     w_next_tx    = parity_bit(r_data, r_parity_odd);
                  end else begin
                     w_next_state = ST_STOP;
                     w_next_tx    = 1'b1;
                  end
               end else begin
                  w_bit_inc = 1'b1;
                  w_next_tx = r_data[r_bit_cnt + BIT_CNT_W'(1)];
               end
            end
         end
         ST_PARITY: begin
            if (w_tick) begin
               w_next_state = ST_STOP;
               w_next_tx    = 1'b1;
               w_load       = 1'b1;
               w_bit_clr    = 1'b1;
            end
         end
         ST_STOP: begin
            w_next_tx = 1'b1;
            if (w_tick) begin
               if (w_last_stop) begin
                  w_next_state = ST_IDLE;
               end else begin
                  w_load    = 1'b1;
                  w_bit_inc = 1'b1;
               end
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_tx    = 1'b1;
         end
      endcase
   end

   assign o_fifo_read = w_start_frame;
   assign o_tx        = r_tx;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_simple_uart_tx.sv
// tb/tb_simple_uart_tx.sv - directed self-checking bench for simple_uart_tx
module tb_simple_uart_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] clkdiv;
   logic        parity_en;
   logic        parity_odd;
   logic        two_stop;
   logic        enable;
   logic [7:0]  fifo_data;
   logic        fifo_empty;
   logic        fifo_read;
   logic        tx;
   logic        busy;

   int          tests = 0;
   int          fails = 0;
   int          reads = 0;
   int          bad_reads = 0;
   logic        s_tx;
   logic        s_busy;
   logic        s_rd;
   logic [7:0]  q[$];

   always #5 clk = ~clk;

   simple_uart_tx #(.DIV_WIDTH(16)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_clkdiv     (clkdiv),
      .i_parity_en  (parity_en),
      .i_parity_odd (parity_odd),
      .i_two_stop   (two_stop),
      .i_enable     (enable),
      .i_fifo_data  (fifo_data),
      .i_fifo_empty (fifo_empty),
      .o_fifo_read  (fifo_read),
      .o_tx         (tx),
      .o_busy       (busy)
   );

   task automatic update_fifo();
      fifo_empty = (q.size() == 0);
      fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
   endtask

   // Samples one cycle at the falling edge, then applies the FIFO pop after the rising edge.
   task automatic step();
      @(negedge clk);
      s_tx   = tx;
      s_busy = busy;
      s_rd   = fifo_read;
      if (s_rd === 1'b1) begin
         reads++;
         if (fifo_empty) bad_reads++;
      end
      @(posedge clk);
      #1;
      if (s_rd === 1'b1 && q.size() != 0) void'(q.pop_front());
      update_fifo();
   endtask

   task automatic check_frame(input string name, input logic [11:0] bits, input int nbits,
                              input int div, input int exp_wait, input logic [15:0] mid_div,
                              input logic mid_par, input logic mid_en);
      int   w;
      int   err_tx;
      int   err_busy;
      int   first;
      logic first_act;
      logic exp_bit;
      w = 0; err_tx = 0; err_busy = 0; first = -1; first_act = 1'b0;
      step();
      tests++;
      if (s_tx !== 1'b1 || s_busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_idle: tx=%b busy=%b, required tx=1 busy=0", name, s_tx, s_busy);
      end
      while (s_rd !== 1'b1 && w < 8) begin
         step();
         w++;
      end
      tests++;
      if (s_rd !== 1'b1) begin
         fails++;
         $display("FAIL %s_read_timeout: fifo_read=%b after %0d cycles, required 1", name, s_rd, w);
         return;
      end
      tests++;
      if (w !== exp_wait) begin
         fails++;
         $display("FAIL %s_read_delay: %0d extra idle cycles, required %0d", name, w, exp_wait);
      end
      for (int k = 0; k < nbits * div; k++) begin
         step();
         if (k == 10) begin
            clkdiv    = mid_div;
            parity_en = mid_par;
            enable    = mid_en;
         end
         exp_bit = bits[k / div];
         if (s_tx !== exp_bit) begin
            if (err_tx == 0) begin
               first     = k;
               first_act = s_tx;
            end
            err_tx++;
         end
         if (s_busy !== 1'b1) err_busy++;
      end
      tests++;
      if (err_tx != 0) begin
         fails++;
         $display("FAIL %s_tx: %0d wrong cycles, first at cycle %0d tx=%b required %b",
                  name, err_tx, first, first_act, bits[first / div]);
      end
      tests++;
      if (err_busy != 0) begin
         fails++;
         $display("FAIL %s_busy: busy low in %0d frame cycles, required 0", name, err_busy);
      end
   endtask

   task automatic finish_idle(input string name);
      step();
      tests++;
      if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_rd !== 1'b0) begin
         fails++;
         $display("FAIL %s_end: tx=%b busy=%b rd=%b, required tx=1 busy=0 rd=0",
                  name, s_tx, s_busy, s_rd);
      end
   endtask

   task automatic set_cfg(input logic [15:0] div, input logic pen, input logic podd, input logic ts);
      clkdiv = div; parity_en = pen; parity_odd = podd; two_stop = ts; enable = 1'b1;
   endtask

   task automatic test_reset();
      int rd_seen;
      rst = 1'b1;
      set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
      q.push_back(8'h55);
      update_fifo();
      step();
      rd_seen = 0;
      repeat (3) begin
         step();
         if (s_rd !== 1'b0) rd_seen++;
      end
      tests++;
      if (rd_seen != 0) begin
         fails++;
         $display("FAIL reset_read: fifo_read high %0d cycles in reset, required 0", rd_seen);
      end
      tests++;
      if (s_tx !== 1'b1 || s_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: tx=%b busy=%b, required tx=1 busy=0", s_tx, s_busy);
      end
      rst = 1'b0;
      q.delete();
      update_fifo();
   endtask

   task automatic test_basic();
      int r0;
      set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
      r0 = reads;
      q.push_back(8'h55);
      update_fifo();
      check_frame("basic_55", 12'h2AA, 10, 4, 0, 16'd4, 1'b0, 1'b1);
      finish_idle("basic_55");
      tests++;
      if (reads - r0 != 1) begin
         fails++;
         $display("FAIL basic_reads: %0d pops, required 1", reads - r0);
      end
   endtask

   task automatic test_parity();
      set_cfg(16'd4, 1'b1, 1'b0, 1'b0);
      q.push_back(8'h07);
      update_fifo();
      check_frame("parity_even", 12'h60E, 11, 4, 0, 16'd4, 1'b1, 1'b1);
      finish_idle("parity_even");
      parity_odd = 1'b1;
      q.push_back(8'h07);
      update_fifo();
      check_frame("parity_odd", 12'h40E, 11, 4, 0, 16'd4, 1'b1, 1'b1);
      finish_idle("parity_odd");
   endtask

   task automatic test_back_to_back();
      int r0;
      set_cfg(16'd3, 1'b1, 1'b0, 1'b1);
      r0 = reads;
      q.push_back(8'hA3);
      q.push_back(8'h0F);
      update_fifo();
      check_frame("b2b_a3", 12'hD46, 12, 3, 0, 16'd3, 1'b1, 1'b1);
      check_frame("b2b_0f", 12'hC1E, 12, 3, 0, 16'd3, 1'b1, 1'b1);
      finish_idle("b2b");
      tests++;
      if (reads - r0 != 2) begin
         fails++;
         $display("FAIL b2b_reads: %0d pops, required 2", reads - r0);
      end
   endtask

   task automatic test_mid_change();
      set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
      q.push_back(8'h55);
      q.push_back(8'h07);
      update_fifo();
      check_frame("midcfg_old", 12'h2AA, 10, 4, 0, 16'd8, 1'b1, 1'b1);
      check_frame("midcfg_new", 12'h60E, 11, 8, 0, 16'd8, 1'b1, 1'b1);
      finish_idle("midcfg");
   endtask

   task automatic test_reset_mid();
      int w;
      set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
      q.push_back(8'h55);
      update_fifo();
      w = 0;
      step();
      while (s_rd !== 1'b1 && w < 8) begin
         step();
         w++;
      end
      repeat (17) step();
      q.push_back(8'h0F);
      update_fifo();
      rst = 1'b1;
      step();
      tests++;
      if (s_tx !== 1'b0 || s_busy !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_bit3: tx=%b busy=%b, required tx=0 busy=1", s_tx, s_busy);
      end
      step();
      tests++;
      if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_rd !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_abort: tx=%b busy=%b rd=%b, required tx=1 busy=0 rd=0",
                  s_tx, s_busy, s_rd);
      end
      rst = 1'b0;
      step();
      tests++;
      if (s_rd !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_resume: fifo_read=%b after release, required 1", s_rd);
      end
      repeat (40) step();
      finish_idle("rstmid");
   endtask

   task automatic test_enable();
      int r0;
      int tx_low;
      set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
      enable = 1'b0;
      r0 = reads;
      tx_low = 0;
      q.push_back(8'h55);
      q.push_back(8'h07);
      update_fifo();
      repeat (5) begin
         step();
         if (s_tx !== 1'b1) tx_low++;
      end
      tests++;
      if (reads != r0 || tx_low != 0) begin
         fails++;
         $display("FAIL enable_off: %0d pops, %0d tx-low cycles, required 0 and 0",
                  reads - r0, tx_low);
      end
      enable = 1'b1;
      check_frame("enable_drop", 12'h2AA, 10, 4, 0, 16'd4, 1'b0, 1'b0);
      finish_idle("enable_drop");
      repeat (4) step();
      tests++;
      if (reads - r0 != 1) begin
         fails++;
         $display("FAIL enable_reads: %0d pops, required 1", reads - r0);
      end
      q.delete();
      update_fifo();
      enable = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
      update_fifo();
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_mid_change();
      test_reset_mid();
      test_enable();
      tests++;
      if (bad_reads != 0) begin
         fails++;
         $display("FAIL empty_read: %0d pops while empty, required 0", bad_reads);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
